// File: rtl/inst_fetch_unit.sv
// Instruction-fetch responder: loadable program store feeding a small in-order response FIFO.
// Optional macro FETCH_OOB_CHECK_EN: out-of-range fetches return a zero instruction and set a sticky error.
module inst_fetch_unit #(
    parameter int NUM_INST    = 32,
    parameter int PC_BIT      = 8,
    parameter int INST_ID_BIT = 8,
    parameter int OP_BIT      = 3,
    parameter int TAG_ID_BIT  = 2,
    parameter int IMM_BIT     = 4,
    parameter int RESP_DEPTH  = 2,
    localparam int INST_BIT   = OP_BIT + 3 * TAG_ID_BIT + IMM_BIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_vld,
    input  logic [PC_BIT-1:0]      load_addr,
    input  logic [INST_BIT-1:0]    load_data,
    input  logic                   fetch_vld,
    output logic                   fetch_rdy,
    input  logic [PC_BIT-1:0]      fetch_pc,
    input  logic [INST_ID_BIT-1:0] fetch_id,
    output logic                   inst_vld,
    input  logic                   inst_rdy,
    output logic [INST_ID_BIT-1:0] inst_id,
    output logic                   inst_last,
    output logic [OP_BIT-1:0]      inst_op,
    output logic [TAG_ID_BIT-1:0]  inst_dst_reg,
    output logic [TAG_ID_BIT-1:0]  inst_src_reg1,
    output logic [TAG_ID_BIT-1:0]  inst_src_reg0,
    output logic [IMM_BIT-1:0]     inst_imm,
    output logic [15:0]            fetch_cnt,
    output logic                   fetch_err
);

    localparam int AW = (NUM_INST > 1) ? $clog2(NUM_INST) : 1;
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam logic [PC_BIT:0]    NUM_INST_W = (PC_BIT + 1)'(NUM_INST);
    localparam logic [PC_BIT-1:0]  LAST_PC    = PC_BIT'(NUM_INST - 1);
    localparam logic [PW-1:0]      PTR_MAX    = PW'(RESP_DEPTH - 1);
    localparam logic [CW-1:0]      DEPTH_C    = CW'(RESP_DEPTH);

    logic [INST_BIT-1:0]    mem_q       [NUM_INST];
    logic [INST_BIT-1:0]    fifo_word_q [RESP_DEPTH];
    logic [INST_ID_BIT-1:0] fifo_id_q   [RESP_DEPTH];
    logic                   fifo_last_q [RESP_DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     fetch_cnt_q, fetch_cnt_d;
    logic            fetch_err_q, fetch_err_d;

    logic                load_ok_s;
    logic                push_s;
    logic                pop_s;
    logic [INST_BIT-1:0] rd_word_s;
    logic [INST_BIT-1:0] push_word_s;
    logic                push_last_s;
    logic [INST_BIT-1:0] head_word_s;

    // Handshakes, write-first memory read and the word/last pushed into the FIFO
    always_comb begin
        load_ok_s   = load_vld && ({1'b0, load_addr} < NUM_INST_W);
        fetch_rdy   = (count_q < DEPTH_C) || inst_rdy;
        inst_vld    = (count_q != {CW{1'b0}});
        push_s      = fetch_vld && fetch_rdy;
        pop_s       = inst_vld && inst_rdy;
        push_last_s = (fetch_pc == LAST_PC);
        if (load_ok_s && (load_addr == fetch_pc)) begin
            rd_word_s = load_data;
        end else begin
            rd_word_s = mem_q[fetch_pc[AW-1:0]];
        end
`ifdef FETCH_OOB_CHECK_EN
        if ({1'b0, fetch_pc} >= NUM_INST_W) begin
            push_word_s = {INST_BIT{1'b0}};
            push_last_s = 1'b1;
            fetch_err_d = fetch_err_q || push_s;
        end else begin
            push_word_s = rd_word_s;
            fetch_err_d = fetch_err_q;
        end
`else
        push_word_s = rd_word_s;
        fetch_err_d = 1'b0;
`endif
    end

    // Pointer, occupancy and consumed-response counter next state
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fetch_cnt_d = fetch_cnt_q;
        if (push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_MAX) ? {PW{1'b0}} : wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d    = (rd_ptr_q == PTR_MAX) ? {PW{1'b0}} : rd_ptr_q + 1'b1;
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end else begin
            rd_ptr_d    = rd_ptr_q;
            fetch_cnt_d = fetch_cnt_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            fetch_cnt_q <= 16'd0;
            fetch_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fetch_cnt_q <= fetch_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // FIFO payload storage; contents only matter while counted as occupied
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            fifo_word_q[wr_ptr_q] <= push_word_s;
            fifo_id_q[wr_ptr_q]   <= fetch_id;
            fifo_last_q[wr_ptr_q] <= push_last_s;
        end
    end

    // Program store: not reset so a loaded program survives rst
    always_ff @(posedge clk) begin
        if (load_ok_s) begin
            mem_q[load_addr[AW-1:0]] <= load_data;
        end
    end

    assign head_word_s   = fifo_word_q[rd_ptr_q];
    assign inst_id       = fifo_id_q[rd_ptr_q];
    assign inst_last     = fifo_last_q[rd_ptr_q];
    assign inst_op       = head_word_s[INST_BIT-1 -: OP_BIT];
    assign inst_dst_reg  = head_word_s[IMM_BIT + 3*TAG_ID_BIT - 1 -: TAG_ID_BIT];
    assign inst_src_reg1 = head_word_s[IMM_BIT + 2*TAG_ID_BIT - 1 -: TAG_ID_BIT];
    assign inst_src_reg0 = head_word_s[IMM_BIT + TAG_ID_BIT - 1 -: TAG_ID_BIT];
    assign inst_imm      = head_word_s[IMM_BIT-1:0];
    assign fetch_cnt     = fetch_cnt_q;
    assign fetch_err     = fetch_err_q;

endmodule
